dpram_sc: RTL and testbench
===========================

Name: dpram_sc

Overview:
Parametrised single-clock true dual-port RAM. It is the next generation of the team's two-port 8x8 RAM. It adds:
- configurable width, depth and read latency
- asynchronous reset with an automatic memory-clear sequencer
- read-valid strobes and held read data
- deterministic cross-port collision rules with a collision flag

It serves as the shared buffer between two producers/consumers in one clock domain.

Parameters:
DW, 8, data width in bits (1..64)
AW, 3, address width; depth = 2**AW
RD_LAT, 2, read latency in cycles; legal values 1 or 2
WR_FIRST, 1, cross-port same-address read/write: 1 = read returns new data, 0 = read returns old data

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
clr_req  input  1  request a full memory clear (honoured only when not busy)
busy  output  1  high while the clear sequencer runs; ports are ignored while busy
ena  input  1  port A request enable
wea  input  1  port A write (1) / read (0), qualified by ena
addra  input  AW  port A address
dina  input  DW  port A write data
douta  output  DW  port A read data, held between reads
valida  output  1  port A read-data strobe, one cycle per read
enb  input  1  port B request enable
web  input  1  port B write / read, qualified by enb
addrb  input  AW  port B address
dinb  input  DW  port B write data
doutb  output  DW  port B read data, held between reads
validb  output  1  port B read-data strobe
collision  output  1  registered one-cycle pulse on a same-address write/write

Behaviour:
- Reset (asynchronous, while rst=1):
  - state=CLEAR, clear counter=0, busy=1
  - douta, doutb = 0; valida, validb, collision = 0
  - read pipelines flushed; memory contents undefined until the clear completes
- FSM states: CLEAR and READY.
  - CLEAR: each edge writes 0 to mem[cnt] and increments cnt. At the edge that writes cnt=2**AW-1, go to READY, so busy=0 from the next cycle. busy is therefore high exactly 2**AW cycles after rst deasserts.
  - READY: clr_req=1 at an edge -> CLEAR with cnt=0 and busy=1 from the next cycle. clr_req is ignored while in CLEAR.
- While busy: ena/enb are ignored. No write, no read, no valid, no collision.
- Write: ena=1 and wea=1 at edge n -> mem[addra]=dina, visible to any read issued at edge n+1. Writes produce no valid.
- Read: ena=1 and wea=0 at edge n -> douta=mem[addra] and valida=1 after edge n+RD_LAT. valida is high for one cycle per read. Back-to-back reads give full throughput, one result per cycle.
  - douta keeps the last read value when no read completes; it is never X.
- Port B is identical to port A.
- Reads already in flight when CLEAR starts complete normally, with data sampled at issue.
- Cross-port same address, same edge:
  - A and B both write: port A data is stored; collision=1 for the cycle after the edge.
  - One port writes, the other reads: the read returns dina/dinb if WR_FIRST=1, or the prior mem value if WR_FIRST=0. No collision.
  - Both read: both get the same data. No collision.
- Addresses are exactly AW bits, so there is no out-of-range case. Arithmetic is unsigned. The clear counter is AW+1 bits to detect the end of the clear.
- rst asserted mid-read or mid-clear: outputs go to reset values immediately, and the clear restarts from 0 after release.

Test Plan:
- Reset/clear (AW=3): release rst -> busy=1 for exactly 8 cycles; then reading addr 0..7 on A returns 0x00 each, valida pulses 8 times, douta stays 0.
- Latency (RD_LAT=2): A writes 0x5A@3; next cycle A reads 3 -> douta=0x5A with valida=1 exactly 2 edges after the read edge. Repeat with RD_LAT=1 -> 1 edge.
- Cross-port: A writes 0x11@2 while B reads 2 in the same edge (old value 0x00) -> doutb=0x11 for WR_FIRST=1, 0x00 for WR_FIRST=0; collision stays 0.
- Collision: A writes 0xAA@5, B writes 0xBB@5 in the same edge -> collision=1 for exactly one cycle; a later read of 5 returns 0xAA.
- clr_req: fill all 8 locations with 0xFF, pulse clr_req -> busy=1 for 8 cycles; ena=1/wea=1 writes of 0x77@0 during busy are ignored; all reads afterwards return 0x00.
- Reset mid-operation: assert rst during back-to-back reads and mid-clear -> valida/validb/collision=0 and douta/doutb=0 immediately; after release, busy=1 for the full 2**AW cycles.

Source files
------------

// File: rtl/dpram_sc.sv
// Single-clock true dual-port RAM with a clear sequencer, read-valid strobes,
// held read data and fixed cross-port collision rules.
module dpram_sc #(
   parameter int unsigned DW       = 8,
   parameter int unsigned AW       = 3,
   parameter int unsigned RD_LAT   = 2,
   parameter bit          WR_FIRST = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          busy,
   input  logic          ena,
   input  logic          wea,
   input  logic [AW-1:0] addra,
   input  logic [DW-1:0] dina,
   output logic [DW-1:0] douta,
   output logic          valida,
   input  logic          enb,
   input  logic          web,
   input  logic [AW-1:0] addrb,
   input  logic [DW-1:0] dinb,
   output logic [DW-1:0] doutb,
   output logic          validb,
   output logic          collision
);

   localparam int unsigned DEPTH    = 1 << AW;
   localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t        state_q;
   logic [AW:0]   cnt_q;
   logic          busy_q;
   logic          collision_q;
   logic [DW-1:0] mem [DEPTH];

   // Port signals gathered into two-entry vectors: index 0 = A, 1 = B.
   logic [1:0]    en_v;
   logic [1:0]    we_v;
   logic [1:0]    rd_v;
   logic [1:0]    wr_v;
   logic [AW-1:0] addr_v [2];
   logic [DW-1:0] din_v  [2];
   logic          ready;
   logic          same_addr;

   assign ready     = (state_q == ST_READY);
   assign en_v      = {enb, ena};
   assign we_v      = {web, wea};
   assign addr_v[0] = addra;
   assign addr_v[1] = addrb;
   assign din_v[0]  = dina;
   assign din_v[1]  = dinb;
   assign same_addr = (addra == addrb);
   assign wr_v      = ready ? (en_v & we_v)  : 2'b00;
   assign rd_v      = ready ? (en_v & ~we_v) : 2'b00;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         unique case (state_q)
            ST_CLEAR: begin
               cnt_q <= cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_q <= ST_READY;
                  busy_q  <= 1'b0;
               end
            end
            ST_READY: begin
               if (clr_req) begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
         endcase
      end
   end

   // Port A is written last so it wins a same-address write/write.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         mem[cnt_q[AW-1:0]] <= '0;
      end else begin
         if (wr_v[1]) mem[addr_v[1]] <= din_v[1];
         if (wr_v[0]) mem[addr_v[0]] <= din_v[0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) collision_q <= 1'b0;
      else     collision_q <= (&wr_v) && same_addr;
   end

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_port
      localparam int OTH = 1 - gi;

      logic [DW-1:0] ram_q;
      logic [DW-1:0] fwd_dat_q;
      logic          fwd_q;
      logic          vld0_q;
      logic [DW-1:0] s0_dat;
      logic [DW-1:0] tail_dat;
      logic          tail_vld;
      logic [DW-1:0] dout_q;
      logic          valid_q;

      always_ff @(posedge clk) begin
         ram_q <= mem[addr_v[gi]];
      end

      // The other port's write data bypasses the array when new-data reads are wanted.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld0_q    <= 1'b0;
            fwd_q     <= 1'b0;
            fwd_dat_q <= '0;
         end else begin
            vld0_q    <= rd_v[gi];
            fwd_q     <= WR_FIRST && rd_v[gi] && wr_v[OTH] && same_addr;
            fwd_dat_q <= din_v[OTH];
         end
      end

      assign s0_dat = fwd_q ? fwd_dat_q : ram_q;

      if (RD_LAT == 2) begin : g_lat2
         logic [DW-1:0] dat1_q;
         logic          vld1_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               dat1_q <= '0;
               vld1_q <= 1'b0;
            end else begin
               dat1_q <= s0_dat;
               vld1_q <= vld0_q;
            end
         end

         assign tail_dat = dat1_q;
         assign tail_vld = vld1_q;
      end else begin : g_lat1
         assign tail_dat = s0_dat;
         assign tail_vld = vld0_q;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= tail_vld;
            if (tail_vld) dout_q <= tail_dat;
         end
      end
   end

   assign busy      = busy_q;
   assign collision = collision_q;
   assign douta     = g_port[0].dout_q;
   assign valida    = g_port[0].valid_q;
   assign doutb     = g_port[1].dout_q;
   assign validb    = g_port[1].valid_q;

endmodule

// File: tb/tb_dpram_sc.sv
// Bench for dpram_sc: two instances (RD_LAT=2/WR_FIRST=1 and RD_LAT=1/WR_FIRST=0)
// share one stimulus stream and are checked every cycle against a behavioural model.
module tb_dpram_sc;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr_req;
   logic          ena, wea, enb, web;
   logic [AW-1:0] addra, addrb;
   logic [DW-1:0] dina, dinb;

   logic          busy0, busy1, coll0, coll1;
   logic          va0, va1, vb0, vb1;
   logic [DW-1:0] da0, da1, db0, db1;

   always #5 clk = ~clk;

   dpram_sc #(.DW(DW), .AW(AW), .RD_LAT(2), .WR_FIRST(1'b1)) u_dut0 (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(da0), .valida(va0),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(db0), .validb(vb0),
      .collision(coll0)
   );

   dpram_sc #(.DW(DW), .AW(AW), .RD_LAT(1), .WR_FIRST(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(da1), .valida(va1),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(db1), .validb(vb1),
      .collision(coll1)
   );

   logic [DW-1:0] dout_w  [2][2];
   logic          valid_w [2][2];
   logic          busy_w  [2];
   logic          coll_w  [2];
   assign dout_w[0][0]  = da0;  assign dout_w[0][1]  = db0;
   assign dout_w[1][0]  = da1;  assign dout_w[1][1]  = db1;
   assign valid_w[0][0] = va0;  assign valid_w[0][1] = vb0;
   assign valid_w[1][0] = va1;  assign valid_w[1][1] = vb1;
   assign busy_w[0] = busy0;    assign busy_w[1] = busy1;
   assign coll_w[0] = coll0;    assign coll_w[1] = coll1;

   // Reference model state
   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   int            clear_left;
   bit            verbose;
   logic [DW-1:0] mem_m   [DEPTH];
   logic          due_vld [2][2][4];
   logic [DW-1:0] due_dat [2][2][4];
   logic [DW-1:0] dout_m  [2][2];
   logic          valid_m [2][2];
   logic          coll_m;
   int            lat_m [2];
   bit            wrf_m [2];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 2; d++) begin
         check_val($sformatf("dut%0d busy", d), 64'(busy_w[d]), 64'(clear_left > 0));
         check_val($sformatf("dut%0d collision", d), 64'(coll_w[d]), 64'(coll_m));
         for (int p = 0; p < 2; p++) begin
            check_val($sformatf("dut%0d valid%s", d, p == 0 ? "a" : "b"),
                      64'(valid_w[d][p]), 64'(valid_m[d][p]));
            check_val($sformatf("dut%0d dout%s", d, p == 0 ? "a" : "b"),
                      64'(dout_w[d][p]), 64'(dout_m[d][p]));
         end
      end
   endtask

   task automatic model_reset();
      clear_left = DEPTH;
      coll_m     = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) begin
            dout_m[d][p]  = '0;
            valid_m[d][p] = 1'b0;
            for (int s = 0; s < 4; s++) begin
               due_vld[d][p][s] = 1'b0;
               due_dat[d][p][s] = '0;
            end
         end
   endtask

   // Applies one rising edge with the currently driven inputs.
   task automatic model_edge();
      logic          wr [2];
      logic          rd [2];
      logic [AW-1:0] ad [2];
      logic [DW-1:0] dn [2];
      logic [DW-1:0] rdat;
      int            slot;
      ad[0] = addra;  ad[1] = addrb;
      dn[0] = dina;   dn[1] = dinb;
      wr[0] = ena && wea;   wr[1] = enb && web;
      rd[0] = ena && !wea;  rd[1] = enb && !web;
      slot = cyc % 4;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) begin
            valid_m[d][p] = 1'b0;
            if (due_vld[d][p][slot]) begin
               valid_m[d][p] = 1'b1;
               dout_m[d][p]  = due_dat[d][p][slot];
               due_vld[d][p][slot] = 1'b0;
            end
         end
      coll_m = 1'b0;
      if (clear_left > 0) begin
         clear_left--;
      end else begin
         for (int p = 0; p < 2; p++)
            if (rd[p])
               for (int d = 0; d < 2; d++) begin
                  rdat = mem_m[ad[p]];
                  if (wrf_m[d] && wr[1-p] && ad[1-p] == ad[p]) rdat = dn[1-p];
                  due_vld[d][p][(cyc + lat_m[d]) % 4] = 1'b1;
                  due_dat[d][p][(cyc + lat_m[d]) % 4] = rdat;
               end
         if (wr[1]) mem_m[ad[1]] = dn[1];
         if (wr[0]) mem_m[ad[0]] = dn[0];
         coll_m = wr[0] && wr[1] && (ad[0] == ad[1]);
         if (clr_req) begin
            clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
         end
      end
      cyc++;
   endtask

   task automatic step();
      if (verbose)
         $display("cyc %0d clr=%b A:en=%b we=%b @%0d d=%02h  B:en=%b we=%b @%0d d=%02h",
                  cyc, clr_req, ena, wea, addra, dina, enb, web, addrb, dinb);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic drive_idle();
      clr_req = 1'b0;
      ena = 1'b0; wea = 1'b0; addra = '0; dina = '0;
      enb = 1'b0; web = 1'b0; addrb = '0; dinb = '0;
   endtask

   task automatic drive_a(input logic en, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
      ena = en; wea = we; addra = ad; dina = dt;
   endtask

   task automatic drive_b(input logic en, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
      enb = en; web = we; addrb = ad; dinb = dt;
   endtask

   task automatic idle_steps(input int n);
      drive_idle();
      repeat (n) step();
   endtask

   task automatic random_steps(input int n);
      for (int i = 0; i < n; i++) begin
         clr_req = ($urandom_range(0, 63) == 0);
         drive_a(1'($urandom), 1'($urandom), AW'($urandom_range(0, 3)), DW'($urandom));
         drive_b(1'($urandom), 1'($urandom), AW'($urandom_range(0, 3)), DW'($urandom));
         step();
      end
      drive_idle();
   endtask

   // Reset asserted between edges; outputs must clear without waiting for a clock.
   task automatic async_reset();
      #3 rst = 1'b1;
      model_reset();
      #1 check_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive_idle();
   endtask

   initial begin
      lat_m[0] = 2; wrf_m[0] = 1'b1;
      lat_m[1] = 1; wrf_m[1] = 1'b0;
      verbose = 1'b1;
      rst = 1'b1;
      drive_idle();
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b0;

      $display("-- clear after reset, then read all zeros");
      idle_steps(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         drive_a(1'b1, 1'b0, AW'(i), '0);
         step();
      end
      idle_steps(3);

      $display("-- write then read latency");
      drive_a(1'b1, 1'b1, 3'd3, 8'h5A); step();
      drive_a(1'b1, 1'b0, 3'd3, 8'h00); step();
      idle_steps(3);

      $display("-- cross-port write/read same address");
      drive_a(1'b1, 1'b1, 3'd2, 8'h11);
      drive_b(1'b1, 1'b0, 3'd2, 8'h00);
      step();
      idle_steps(3);

      $display("-- write/write collision");
      drive_a(1'b1, 1'b1, 3'd5, 8'hAA);
      drive_b(1'b1, 1'b1, 3'd5, 8'hBB);
      step();
      idle_steps(1);
      drive_a(1'b1, 1'b0, 3'd5, 8'h00); step();
      idle_steps(3);

      $display("-- clr_req with writes ignored while busy");
      for (int i = 0; i < DEPTH; i++) begin
         drive_a(1'b1, 1'b1, AW'(i), 8'hFF);
         step();
      end
      drive_idle();
      clr_req = 1'b1; step();
      clr_req = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drive_a(1'b1, 1'b1, 3'd0, 8'h77);
         step();
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive_a(1'b1, 1'b0, AW'(i), '0);
         drive_b(1'b1, 1'b0, AW'(DEPTH - 1 - i), '0);
         step();
      end
      idle_steps(3);

      verbose = 1'b0;
      $display("-- random traffic");
      random_steps(1500);

      verbose = 1'b1;
      $display("-- reset during back-to-back reads");
      for (int i = 0; i < 6; i++) begin
         drive_a(1'b1, 1'b1, AW'(i), DW'($urandom));
         step();
      end
      for (int i = 0; i < 4; i++) begin
         drive_a(1'b1, 1'b0, AW'(i), '0);
         drive_b(1'b1, 1'b0, AW'(5 - i), '0);
         step();
      end
      async_reset();
      idle_steps(DEPTH + 2);
      verbose = 1'b0;
      random_steps(200);

      verbose = 1'b1;
      $display("-- reset during clear");
      clr_req = 1'b1; step();
      clr_req = 1'b0;
      idle_steps(3);
      async_reset();
      idle_steps(DEPTH + 2);
      verbose = 1'b0;
      random_steps(200);
      idle_steps(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
